mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 114 +++++++++++
 tb/tb_mem_access_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - strobe-to-req/ack bridge with auto-increment address, timeout abort and drop counting
module mem_access_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 15
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clear_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        drop_cnt
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       drop;
    logic       abort;

    // In IDLE only the read half of a simultaneous read+write is lost; in ACCESS any strobe is lost.
    always_comb begin
        drop  = 1'b0;
        abort = 1'b0;
        if (state == IDLE) begin
            drop = read & write;
        end else begin
            drop  = read | write;
            abort = !mem_ack && (wait_cnt == WAIT_LAST);
        end
    end

    assign busy = (state == ACCESS);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= BASE_ADDR;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            timeout_err <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            rdata_valid <= 1'b0;

            if (drop) begin
                if (clear_err)
                    drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (clear_err) begin
                drop_cnt <= 8'd0;
            end

            if (abort)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (write) begin
                        mem_wdata <= wdata;
                        mem_we    <= 1'b1;
                        mem_req   <= 1'b1;
                        state     <= ACCESS;
                    end else if (read) begin
                        mem_we  <= 1'b0;
                        mem_req <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                        mem_addr <= mem_addr + 1'b1;
                        if (!mem_we) begin
                            rdata       <= mem_rdata;
                            rdata_valid <= 1'b1;
                        end
                    end else if (abort) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int         TIMEOUT = 15;
    localparam logic [7:0] BASE_B  = 8'hFE;

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        clear_err = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        mem_req, mem_we, rdata_valid, busy, timeout_err;
    logic [7:0]  mem_addr, drop_cnt;
    logic [31:0] mem_wdata, rdata;

    logic        mem_req_b, mem_we_b, rdata_valid_b, busy_b, timeout_err_b;
    logic [7:0]  mem_addr_b, drop_cnt_b;
    logic [31:0] mem_wdata_b, rdata_b;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_addr;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_drop;
    logic        exp_terr;

    mem_access_unit #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(8'h00), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetN(resetN), .read(read), .write(write), .wdata(wdata),
        .clear_err(clear_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rdata(rdata),
        .rdata_valid(rdata_valid), .busy(busy), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
    );

    mem_access_unit #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(BASE_B), .TIMEOUT(TIMEOUT)) dut_b (
        .clock(clock), .resetN(resetN), .read(read), .write(write), .wdata(wdata),
        .clear_err(clear_err), .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rdata(rdata_b),
        .rdata_valid(rdata_valid_b), .busy(busy_b), .timeout_err(timeout_err_b), .drop_cnt(drop_cnt_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic model_reset();
        exp_addr  = 8'h00;
        exp_rdata = '0;
        exp_drop  = 8'd0;
        exp_terr  = 1'b0;
    endtask

    // One transaction: strobe, optional in-flight strobe at cycle drop_at, ack on cycle ack_after (0 = never).
    task automatic run_access(input logic wr, input logic rd_too, input logic [31:0] d,
                              input int ack_after, input int drop_at, input logic [31:0] rv);
        int n, pulses, pulses_b, exp_n, exp_p;
        logic ok_done;
        logic [7:0] addr_b;
        write = wr;
        read  = ~wr | rd_too;
        wdata = d;
        if (wr && rd_too) exp_drop = sat_inc(exp_drop);
        tick();
        read  = 1'b0;
        write = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || rdata_valid !== 1'b0 || mem_req_b !== 1'b1) begin
            errors++;
            $display("FAIL req_rise: mem_req=%b busy=%b rdata_valid=%b mem_req_b=%b required 1 1 0 1",
                     mem_req, busy, rdata_valid, mem_req_b);
        end
        n = 0; pulses = 0; pulses_b = 0;
        while (mem_req === 1'b1 && n < 300) begin
            n++;
            addr_b = exp_addr + BASE_B;
            checks++;
            if (mem_addr !== exp_addr || mem_addr_b !== addr_b || mem_we !== wr || mem_we_b !== wr ||
                (wr && (mem_wdata !== d || mem_wdata_b !== d))) begin
                errors++;
                $display("FAIL bus_hold: cycle %0d addr=%h addr_b=%h we=%b wdata=%h required %h %h %b %h",
                         n, mem_addr, mem_addr_b, mem_we, mem_wdata, exp_addr, addr_b, wr, d);
            end
            mem_ack   = (n == ack_after);
            mem_rdata = (n == ack_after) ? rv : $urandom();
            if (n == drop_at) begin
                read = 1'b1;
                exp_drop = sat_inc(exp_drop);
            end
            tick();
            read    = 1'b0;
            mem_ack = 1'b0;
            if (rdata_valid === 1'b1) pulses++;
            if (rdata_valid_b === 1'b1) pulses_b++;
        end
        ok_done = (ack_after >= 1) && (ack_after <= TIMEOUT);
        exp_n   = ok_done ? ack_after : TIMEOUT;
        exp_p   = (ok_done && !wr) ? 1 : 0;
        if (ok_done) begin
            exp_addr = exp_addr + 8'd1;
            if (!wr) exp_rdata = rv;
        end else begin
            exp_terr = 1'b1;
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL req_cycles: mem_req high %0d cycles, required %0d", n, exp_n);
        end
        checks++;
        if (pulses != exp_p || pulses_b != exp_p) begin
            errors++;
            $display("FAIL valid_pulses: got %0d/%0d, required %0d", pulses, pulses_b, exp_p);
        end
        checks++;
        if (rdata !== exp_rdata || rdata_b !== exp_rdata) begin
            errors++;
            $display("FAIL rdata: got %h/%h, required %h", rdata, rdata_b, exp_rdata);
        end
        checks++;
        if (timeout_err !== exp_terr || drop_cnt !== exp_drop || busy !== 1'b0 ||
            timeout_err_b !== exp_terr || drop_cnt_b !== exp_drop || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL status: terr=%b drop=%0d busy=%b, required %b %0d 0",
                     timeout_err, drop_cnt, busy, exp_terr, exp_drop);
        end
        addr_b = exp_addr + BASE_B;
        checks++;
        if (mem_addr !== exp_addr || mem_addr_b !== addr_b) begin
            errors++;
            $display("FAIL addr_after: got %h/%h, required %h/%h", mem_addr, mem_addr_b, exp_addr, addr_b);
        end
    endtask

    task automatic test_reset();
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0 ||
            rdata !== 32'h0 || rdata_valid !== 1'b0 || timeout_err !== 1'b0 || drop_cnt !== 8'd0 ||
            busy !== 1'b0 || mem_addr_b !== BASE_B) begin
            errors++;
            $display("FAIL reset_values: req=%b we=%b addr=%h addr_b=%h rdata=%h drop=%0d terr=%b, required all zero and addr_b=fe",
                     mem_req, mem_we, mem_addr, mem_addr_b, rdata, drop_cnt, timeout_err);
        end
        repeat (2) tick();
        resetN = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_basic_read();
        run_access(1'b0, 1'b0, 32'h0, 2, 0, 32'hDEADBEEF);
    endtask

    task automatic test_write_drop();
        run_access(1'b1, 1'b0, 32'h12345678, 3, 1, 32'h0);
    endtask

    task automatic test_read_write_same();
        run_access(1'b1, 1'b1, $urandom(), 1, 0, 32'h0);
    endtask

    task automatic test_idle_ack();
        mem_ack   = 1'b1;
        mem_rdata = $urandom();
        repeat (3) tick();
        checks++;
        if (mem_req !== 1'b0 || rdata_valid !== 1'b0 || rdata !== exp_rdata || mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL idle_ack: req=%b valid=%b rdata=%h addr=%h, required 0 0 %h %h",
                     mem_req, rdata_valid, rdata, mem_addr, exp_rdata, exp_addr);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_timeout_clear();
        run_access(1'b0, 1'b0, 32'h0, 0, 0, $urandom());
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        exp_terr = 1'b0;
        exp_drop = 8'd0;
        checks++;
        if (timeout_err !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clear_err: terr=%b drop=%0d, required 0 0", timeout_err, drop_cnt);
        end
        run_access(1'b0, 1'b0, 32'h0, TIMEOUT, 0, $urandom());
    endtask

    task automatic test_clear_priority();
        int n;
        read = 1'b1;
        tick();
        read = 1'b1;
        clear_err = 1'b1;
        tick();
        read = 1'b0;
        checks++;
        if (drop_cnt !== 8'd1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_vs_drop: drop=%0d terr=%b, required 1 0", drop_cnt, timeout_err);
        end
        n = 1;
        while (mem_req === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        clear_err = 1'b0;
        exp_drop = 8'd0;
        exp_terr = 1'b1;
        checks++;
        if (timeout_err !== 1'b1 || drop_cnt !== 8'd0 || n != TIMEOUT) begin
            errors++;
            $display("FAIL clear_vs_timeout: terr=%b drop=%0d req_cycles=%0d, required 1 0 %0d",
                     timeout_err, drop_cnt, n, TIMEOUT);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++)
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                       $urandom_range(1, TIMEOUT + 3), $urandom_range(0, 3), $urandom());
    endtask

    task automatic test_saturation();
        int busy_left;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        exp_drop = 8'd0;
        exp_terr = 1'b0;
        busy_left = 0;
        read = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (busy_left == 0) begin
                busy_left = TIMEOUT;
            end else begin
                exp_drop = sat_inc(exp_drop);
                busy_left--;
                if (busy_left == 0) exp_terr = 1'b1;
            end
            if (i == 16) begin
                checks++;
                if (drop_cnt !== exp_drop) begin
                    errors++;
                    $display("FAIL drop_midway: got %0d, required %0d", drop_cnt, exp_drop);
                end
            end
        end
        read = 1'b0;
        for (int i = 0; i < 20 && mem_req === 1'b1; i++) tick();
        exp_terr = 1'b1;
        checks++;
        if (drop_cnt !== 8'd255 || drop_cnt_b !== 8'd255 || timeout_err !== exp_terr ||
            mem_addr !== exp_addr || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_saturate: drop=%0d terr=%b addr=%h req=%b, required 255 1 %h 0",
                     drop_cnt, timeout_err, mem_addr, mem_req, exp_addr);
        end
    endtask

    task automatic test_reset_mid();
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'h00 || mem_addr_b !== BASE_B ||
            drop_cnt !== 8'd0 || timeout_err !== 1'b0 || rdata !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: req=%b busy=%b addr=%h addr_b=%h drop=%0d terr=%b, required 0 0 00 fe 0 0",
                     mem_req, busy, mem_addr, mem_addr_b, drop_cnt, timeout_err);
        end
        tick();
        resetN = 1'b1;
        model_reset();
        tick();
        checks++;
        if (mem_req !== 1'b0 || rdata_valid !== 1'b0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL after_reset: req=%b valid=%b addr=%h, required 0 0 00", mem_req, rdata_valid, mem_addr);
        end
        run_access(1'b0, 1'b0, 32'h0, 1, 0, $urandom());
    endtask

    task automatic test_wrap();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < 256; i++)
            run_access(1'($urandom_range(0, 1)), 1'b0, $urandom(), $urandom_range(1, 3), 0, $urandom());
        checks++;
        if (mem_addr_b !== 8'hFE || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL addr_wrap: addr_b=%h addr=%h, required fe 00", mem_addr_b, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_drop();
        test_read_write_same();
        test_idle_ack();
        test_timeout_clear();
        test_clear_priority();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
